// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard scoreboard with in-flight destination tracking, optional FORWARD_EN bypass
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter int ZERO_IGN = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              id_valid,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              isSrc2,
    input  logic              flush,
    output logic              freez,
    output logic [2:0]        hz_slot,
    output logic [CNT_W-1:0]  stall_cnt
`ifdef FORWARD_EN
    ,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2
`endif
);

    // Index of the MEM slot; clamped so a DEPTH=1 build still elaborates.
    localparam int S1 = (DEPTH > 1) ? 1 : 0;

    logic [DEPTH-1:0]  slot_v;
    logic [DEPTH-1:0]  slot_ld;
    logic [REG_AW-1:0] slot_dest [DEPTH];

    logic [DEPTH-1:0]  m1;
    logic [DEPTH-1:0]  m2;
    logic [DEPTH-1:0]  hit;
    logic [DEPTH-1:0]  stall_hit;
    logic              new_v;

    // Per-slot source matches and the subset of hits that must stall.
    always_comb begin
        m1        = '0;
        m2        = '0;
        hit       = '0;
        stall_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m1[k]  = slot_v[k] && (slot_dest[k] == src1) && !((ZERO_IGN != 0) && (src1 == '0));
            m2[k]  = slot_v[k] && (slot_dest[k] == src2) && !((ZERO_IGN != 0) && (src2 == '0));
            hit[k] = m1[k] || (isSrc2 && m2[k]);
`ifdef FORWARD_EN
            // Slots 0/1 are bypassed; only a load still in EXE cannot be.
            if (k == 0)
                stall_hit[k] = hit[k] && slot_ld[k];
            else if (k == 1)
                stall_hit[k] = 1'b0;
            else
                stall_hit[k] = hit[k];
`else
            stall_hit[k] = hit[k];
`endif
        end
    end

    // Stall request, blamed slot (youngest stalling hit) and the new slot-0 valid bit.
    always_comb begin
        freez   = !rst && enable && id_valid && !flush && (|stall_hit);
        hz_slot = '0;
        if (freez) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (stall_hit[k])
                    hz_slot = 3'(k);
            end
        end
        new_v = id_valid && id_wb_en && !freez && !flush;
    end

`ifdef FORWARD_EN
    // Bypass selects: EXE result beats MEM result; loads in EXE cannot be bypassed.
    always_comb begin
        fwd_sel1 = 2'd0;
        fwd_sel2 = 2'd0;
        if (!rst) begin
            if (m1[0] && !slot_ld[0])
                fwd_sel1 = 2'd1;
            else if (m1[S1] && (S1 == 1))
                fwd_sel1 = 2'd2;
            if (isSrc2) begin
                if (m2[0] && !slot_ld[0])
                    fwd_sel2 = 2'd1;
                else if (m2[S1] && (S1 == 1))
                    fwd_sel2 = 2'd2;
            end
        end
    end
`endif

    // In-flight pipeline: everything shifts one stage per clock, no hold.
    always_ff @(posedge clk) begin
        for (int k = DEPTH - 1; k >= 1; k--) begin
            slot_v[k]    <= slot_v[k-1];
            slot_ld[k]   <= slot_ld[k-1];
            slot_dest[k] <= slot_dest[k-1];
        end
        slot_v[0]    <= new_v;
        slot_ld[0]   <= id_mem_read;
        slot_dest[0] <= id_dest;
        if (rst)
            slot_v <= '0;
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (freez && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard against a cycle-history reference model
module tb_hazard_scoreboard;

    localparam int REG_AW   = 5;
    localparam int DEPTH    = 3;
    localparam int ZERO_IGN = 1;
    localparam int CNT_W    = 6;
    localparam int HN       = 4096;

    logic              clk = 1'b1;
    logic              rst, enable, id_valid, id_wb_en, id_mem_read, isSrc2, flush;
    logic [REG_AW-1:0] id_dest, src1, src2;
    logic              freez;
    logic [2:0]        hz_slot;
    logic [CNT_W-1:0]  stall_cnt;
    logic [1:0]        fwd_sel1, fwd_sel2;

    hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .ZERO_IGN(ZERO_IGN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .id_dest(id_dest), .src1(src1), .src2(src2),
        .isSrc2(isSrc2), .flush(flush), .freez(freez), .hz_slot(hz_slot), .stall_cnt(stall_cnt)
`ifdef FORWARD_EN
        , .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
`endif
    );

`ifndef FORWARD_EN
    assign fwd_sel1 = 2'd0;
    assign fwd_sel2 = 2'd0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic             f;
        logic [2:0]       hz;
        logic [CNT_W-1:0] cnt;
        logic [1:0]       f1;
        logic [1:0]       f2;
        bit               all;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference history: what entered the pipeline at the end of each cycle.
    bit               h_v  [HN];
    logic [REG_AW-1:0] h_d [HN];
    bit               h_ld [HN];
    int               cyc_n    = 0;
    int               last_rst = -1;
    int               m_cnt    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_n, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("freez", int'(freez), int'(e.f));
            if (e.all) begin
                chk("hz_slot", int'(hz_slot), int'(e.hz));
                chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
`ifdef FORWARD_EN
                chk("fwd_sel1", int'(fwd_sel1), int'(e.f1));
                chk("fwd_sel2", int'(fwd_sel2), int'(e.f2));
`endif
            end
        end
    end

    function automatic bit mt(input int age_k, input logic [REG_AW-1:0] s);
        int t;
        t = cyc_n - 1 - age_k;
        if (t < 0 || t <= last_rst) return 0;
        if (ZERO_IGN != 0 && s == 0) return 0;
        return h_v[t % HN] && (h_d[t % HN] == s);
    endfunction

    function automatic bit ld_at(input int age_k);
        int t;
        t = cyc_n - 1 - age_k;
        if (t < 0) return 0;
        return h_ld[t % HN];
    endfunction

    // Drive one cycle, push the expected outputs, advance the reference model.
    task automatic cyc(input bit r, input bit en, input bit v, input bit wb, input bit ld,
                       input int d, input int s1, input int s2, input bit is2, input bit fl,
                       input bit all);
        exp_t e;
        bit   any_stall;
        int   first;
        rst = r; enable = en; id_valid = v; id_wb_en = wb; id_mem_read = ld;
        id_dest = REG_AW'(d); src1 = REG_AW'(s1); src2 = REG_AW'(s2); isSrc2 = is2; flush = fl;
        any_stall = 0;
        first = -1;
        for (int k = 0; k < DEPTH; k++) begin
            bit h, st;
            h = mt(k, src1) || (is2 && mt(k, src2));
`ifdef FORWARD_EN
            st = (k == 0) ? (h && ld_at(0)) : (k == 1) ? 1'b0 : h;
`else
            st = h;
`endif
            if (st && first < 0) first = k;
            any_stall |= st;
        end
        e.f   = !r && en && v && !fl && any_stall;
        e.hz  = e.f ? 3'(first) : 3'd0;
        e.cnt = CNT_W'(m_cnt);
        e.f1  = 2'd0;
        e.f2  = 2'd0;
        if (!r) begin
            if (mt(0, src1) && !ld_at(0)) e.f1 = 2'd1;
            else if (mt(1, src1)) e.f1 = 2'd2;
            if (is2) begin
                if (mt(0, src2) && !ld_at(0)) e.f2 = 2'd1;
                else if (mt(1, src2)) e.f2 = 2'd2;
            end
        end
        e.all = all;
        exp_q.push_back(e);
        h_v[cyc_n % HN]  = v && wb && !e.f && !fl;
        h_d[cyc_n % HN]  = REG_AW'(d);
        h_ld[cyc_n % HN] = ld;
        if (r) begin
            m_cnt = 0;
            last_rst = cyc_n;
        end else if (e.f && m_cnt < (1 << CNT_W) - 1) begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    initial begin
        #1;
        // reset: power-up counter is unknown in the first cycle
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // write r3, then a reader of r3 held while stalled
        cyc(0, 1, 1, 1, 0, 3, 1, 2, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 0, 3, 2, 0, 0, 1);
        // src2 only counts when isSrc2=1
        cyc(0, 1, 1, 1, 0, 3, 1, 2, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 1, 3, 0, 0, 1);
        cyc(0, 1, 1, 1, 0, 3, 1, 2, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, 1, 3, 1, 0, 1);
        // r0 never hazards
        cyc(0, 1, 1, 1, 0, 0, 1, 2, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        // flush beats a hazard and leaves no entry
        cyc(0, 1, 1, 1, 0, 4, 1, 2, 0, 0, 1);
        cyc(0, 1, 1, 1, 0, 5, 4, 2, 0, 1, 1);
        cyc(0, 1, 1, 0, 0, 0, 5, 2, 0, 0, 1);
        // two sources hitting different slots: one continuous stall
        cyc(0, 1, 1, 1, 0, 6, 1, 2, 0, 0, 1);
        cyc(0, 1, 1, 1, 0, 7, 1, 2, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, 7, 6, 1, 0, 1);
        // load followed by dependent instruction
        cyc(0, 1, 1, 1, 1, 5, 1, 2, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, 5, 2, 0, 0, 1);
        // enable=0 mid-stall forces freez low; reset afterwards
        cyc(0, 1, 1, 1, 0, 9, 1, 2, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 9, 2, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 9, 2, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // reset mid-stall discards in-flight entries
        cyc(0, 1, 1, 1, 0, 2, 1, 3, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 2, 3, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 0, 2, 3, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 2, 3, 0, 0, 1);
        // randomized traffic over a small register range; long enough to saturate the counter
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 199) == 0), 1,
                ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), ($urandom_range(0, 9) == 0), 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
